uart_tx_fifo_drain: RTL



---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx_fifo_drain.sv | 129 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmit path (and later the receive path).
//   tx_state_e          : transmitter state encoding
//   PAR_NONE/EVEN/ODD   : PARITY_MODE values
//   DEFAULT_CLKS_PER_BIT: 100 MHz / 115200 baud
//   par_seed()          : initial parity accumulator value for a parity mode
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Odd parity starts the accumulator at 1 so the XOR of the data bits
  // lands directly on the bit that makes the total count of ones odd.
  function automatic logic par_seed(input int mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts clk cycles while en_i is high and pulses tick_o
// on the last cycle of each bit period, wrapping back to 0 on that edge.
//   clk, reset : clock, synchronous active-high reset
//   clr_i      : force the counter to 0 (start of a new frame)
//   en_i       : count this cycle
//   tick_o     : combinational, high on the final cycle of a bit period
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (en_i)   cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining an 8-bit byte FIFO. Pops the head byte whenever
// the line is idle, the FIFO is non-empty and txEnable is high, then sends
// start bit, 8 data bits LSB first, optional parity and 1 or 2 stop bits.
//   clk, reset : clock, synchronous active-high reset
//   fifoData   : FIFO head byte, valid while fifoEmpty=0
//   fifoEmpty  : FIFO empty flag
//   fifoRe     : FIFO pop strobe, single-cycle, combinational
//   txEnable   : allow new frames; a frame in flight always completes
//   tx         : registered serial line, idle high
//   txBusy     : frame in progress
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_MODE  = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] fifoData,
  input  logic       fifoEmpty,
  output logic       fifoRe,
  input  logic       txEnable,
  output logic       tx,
  output logic       txBusy
);
  // Mode 3 is unused and falls back to no parity.
  localparam bit HAS_PAR  = (PARITY_MODE == PAR_EVEN) || (PARITY_MODE == PAR_ODD);
  localparam bit TWO_STOP = (STOP_BITS == 2);

  tx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       par_q, par_d;
  logic       stop_q, stop_d;   // first stop bit already sent
  logic       tx_q, tx_d;
  logic       tick;

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (fifoRe),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    par_d     = par_q;
    stop_d    = stop_q;
    fifoRe    = 1'b0;
    tx_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (!fifoEmpty && txEnable && !reset) begin
          fifoRe    = 1'b1;
          state_d   = START;
          shift_d   = fifoData;
          par_d     = par_seed(PARITY_MODE);
          bit_idx_d = 3'd0;
          stop_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d   = DATA;
          bit_idx_d = 3'd0;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          par_d     = par_q ^ shift_q[0];
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = HAS_PAR ? PARITY : STOP;
            stop_d  = 1'b0;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: begin
        if (tick) begin
          if (TWO_STOP && !stop_q) stop_d  = 1'b1;
          else                     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered: drive the level belonging to the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_d;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      par_q     <= 1'b0;
      stop_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      par_q     <= par_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
    end
  end

  assign tx     = tx_q;
  assign txBusy = (state_q != IDLE);

endmodule
